maj_vector_loader: RTL and testbench
====================================

// Module: maj_vector_loader
// PURPOSE
// - Upstream feeder and checker for the combinational N-input majority core (ports x0..x{N-1}, y0).
// - Assembles an N-bit vector from a stream of W-bit chunks (valid/ready).
// - Holds the vector stable on x_out and samples the core's y0 after a settle window.
// - Returns the sampled result together with an incrementally computed popcount reference, a mismatch flag and an error counter.
// PARAMETERS
// - N       65  majority width; must be odd and >= 3
// - W       8   chunk width; must be >= 1
// - SETTLE  1   cycles x_out is held before maj_in is sampled; must be >= 1
// - ERRW    16  width of err_count
// PORTS
// - clk           in   1                rising-edge clock
// - rst           in   1                synchronous, active-high reset
// - in_valid      in   1                chunk valid
// - in_ready      out  1                chunk accepted when in_valid & in_ready
// - in_data       in   W                chunk; chunk k maps to bits [k*W +: W]
// - x_out         out  N                vector driven to the core x0..x{N-1}
// - maj_in        in   1                core output y0
// - out_valid     out  1                result valid
// - out_ready     in   1                result consumed when out_valid & out_ready
// - out_y         out  1                sampled maj_in
// - out_ref       out  1                reference result: hw >= (N+1)/2
// - out_hw        out  clog2(N+1)       popcount of the vector
// - out_mismatch  out  1                out_y != out_ref
// - err_count     out  ERRW             saturating count of mismatching results
// BEHAVIOUR
// - Chunking: NCH = ceil(N/W) chunks per vector. In the last chunk only the low N-(NCH-1)*W bits are used.
//   Unused upper bits are masked: they are not stored and not counted.
// - FSM states: LOAD, SETTLE, OUTPUT. Reset state is LOAD.
// - in_ready = (state==LOAD) & ~rst (combinational).
// - LOAD, on each accept:
//   - the masked chunk is written into shadow[k*W +: W];
//   - hw_acc += popcount(masked chunk);
//   - k++.
// - LOAD, on accept of chunk NCH-1 (edge e0):
//   - x_out <= shadow with the final chunk merged;
//   - hw latched;
//   - k <= 0, hw_acc <= 0;
//   - state -> SETTLE, settle counter loaded with SETTLE-1.
// - Between vectors: x_out changes only at e0. It is held through SETTLE, OUTPUT and the whole next LOAD.
// - SETTLE: the counter decrements each cycle. At edge e0+SETTLE:
//   - out_y <= maj_in, out_ref and out_hw <= latched values, out_mismatch <= (maj_in != ref);
//   - err_count increments if mismatch, saturating at 2^ERRW-1;
//   - out_valid <= 1, state -> OUTPUT.
//   - Latency: last chunk accept -> out_valid is SETTLE cycles.
// - OUTPUT: in_ready = 0. All out_* are held stable while out_valid & ~out_ready.
//   - On out_ready: out_valid <= 0 and state -> LOAD.
//   - The earliest next chunk accept is the cycle after the handshake.
// - out_ready is ignored in LOAD and SETTLE. in_valid is ignored outside LOAD. in_data is don't-care when in_valid = 0.
// - Reset (including mid-operation): at the first edge with rst = 1, all of the following clear to 0:
//   - out_valid, out_y, out_ref, out_hw, out_mismatch, err_count;
//   - x_out, shadow, hw_acc, k;
//   - state -> LOAD.
//   - A partial vector is discarded. The first chunk after rst deasserts is chunk 0.
// - Arithmetic: hw_acc is clog2(N+1) bits and cannot overflow. The threshold (N+1)/2 is a constant.
// STRUCTURE
// - Package maj_pkg:
//   - state enum {LOAD, SETTLE, OUTPUT};
//   - functions hw_width(N) = clog2(N+1), maj_threshold(N) = (N+1)/2, num_chunks(N,W);
//   - last-chunk mask function.
// - Sub-module chunk_popcount (#W): combinational popcount of one masked W-bit chunk, output clog2(W+1) bits.
// - Elaboration check: fatal if N is even, N < 3, W < 1 or SETTLE < 1.
// TESTING (N=65, W=8, SETTLE=1; core model y0 = popcount>=33 unless overridden)
// - All-zero: 9 chunks of 0x00.
//   -> x_out=0, out_hw=0, out_ref=0, out_y=0, out_mismatch=0; out_valid 1 cycle after the 9th accept.
// - Threshold high: chunks FF,FF,FF,FF,00,00,00,00,01.
//   -> out_hw=33, out_ref=1, x_out[64]=1, out_mismatch=0.
// - Threshold low plus fault: 32 ones (FF x4, then 00 x5), maj_in forced 1.
//   -> out_hw=32, out_ref=0, out_y=1, out_mismatch=1, err_count=1.
// - Last-chunk masking: chunks 00 x8, then FE.
//   -> x_out=0, out_hw=0, out_ref=0.
// - Backpressure: out_ready held 0 for 5 cycles after out_valid.
//   -> out_* and x_out stable, in_ready=0; after out_ready=1, out_valid drops and in_ready=1 the next cycle.
// - Reset mid-load: rst for 1 cycle after 4 chunks of FF, then 9 chunks of 00.
//   -> out_hw=0, err_count=0, no result emitted for the aborted vector.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared types and elaboration-time helpers for the majority-core vector loader.
package maj_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    function automatic int hw_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int maj_threshold(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int num_chunks(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    // Bit i of chunk k carries a vector bit only if it lands below n.
    function automatic logic chunk_bit_used(input int n, input int w, input int k, input int i);
        return ((k * w + i) < n);
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one (already masked) W-bit chunk.
module chunk_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]             i_data,
    output logic [$clog2(W+1)-1:0]   o_count
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_data[i]);
        end
    end

endmodule

// File: rtl/maj_vector_loader.sv
// Assembles N-bit vectors from W-bit chunks, drives the majority core, samples its
// result after a settle window and compares it against a popcount reference.
module maj_vector_loader
    import maj_pkg::*;
#(
    parameter int N      = 65,
    parameter int W      = 8,
    parameter int SETTLE = 1,
    parameter int ERRW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_data,
    output logic [N-1:0]              x_out,
    input  logic                      maj_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_y,
    output logic                      out_ref,
    output logic [$clog2(N+1)-1:0]    out_hw,
    output logic                      out_mismatch,
    output logic [ERRW-1:0]           err_count
);

    localparam int HW_W = hw_width(N);
    localparam int NCH  = num_chunks(N, W);
    localparam int SW   = NCH * W;
    localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PCW  = $clog2(W + 1);
    localparam int THR  = maj_threshold(N);

    if ((N % 2) == 0 || N < 3 || W < 1 || SETTLE < 1) begin : g_param_check
        $fatal(1, "maj_vector_loader: illegal parameters N=%0d W=%0d SETTLE=%0d", N, W, SETTLE);
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_shadow;
    logic [SW-1:0]     w_shadow_nxt;
    logic [KW-1:0]     r_k;
    logic [HW_W-1:0]   r_hw_acc;
    logic [HW_W-1:0]   r_hw_lat;
    logic [SCW-1:0]    r_settle;
    logic [N-1:0]      r_x_out;
    logic              r_out_valid;
    logic              r_out_y;
    logic              r_out_ref;
    logic [HW_W-1:0]   r_out_hw;
    logic              r_out_mismatch;
    logic [ERRW-1:0]   r_err_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;
    logic [W-1:0]      w_mask;
    logic [W-1:0]      w_masked;
    logic [PCW-1:0]    w_pc;
    logic [HW_W-1:0]   w_hw_sum;
    logic              w_ref_lat;
    logic              w_mismatch;

    assign w_accept   = in_valid & w_in_ready;
    assign w_last     = (r_k == KW'(NCH - 1));
    assign w_masked   = in_data & w_mask;
    assign w_hw_sum   = r_hw_acc + HW_W'(w_pc);
    assign w_ref_lat  = (r_hw_lat >= HW_W'(THR));
    assign w_mismatch = (maj_in != w_ref_lat);

    // Only the final chunk can have bits beyond N; those are dropped before store and count.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_mask[i] = chunk_bit_used(N, W, int'(r_k), i);
        end
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[int'(r_k) * W +: W] = w_masked;
    end

    chunk_popcount #(.W(W)) u_chunk_popcount (
        .i_data  (w_masked),
        .o_count (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = ~rst;
                if (w_accept && w_last) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow       <= '0;
            r_k            <= '0;
            r_hw_acc       <= '0;
            r_hw_lat       <= '0;
            r_settle       <= '0;
            r_x_out        <= '0;
            r_out_valid    <= 1'b0;
            r_out_y        <= 1'b0;
            r_out_ref      <= 1'b0;
            r_out_hw       <= '0;
            r_out_mismatch <= 1'b0;
            r_err_count    <= '0;
        end else begin
            if (w_accept) begin
                r_shadow <= w_shadow_nxt;
                if (w_last) begin
                    // x_out only ever changes here, so the core sees a stable vector until the next one completes.
                    r_x_out  <= w_shadow_nxt[N-1:0];
                    r_hw_lat <= w_hw_sum;
                    r_k      <= '0;
                    r_hw_acc <= '0;
                    r_settle <= SCW'(SETTLE - 1);
                end else begin
                    r_k      <= r_k + KW'(1);
                    r_hw_acc <= w_hw_sum;
                end
            end

            if (r_state == ST_SETTLE) begin
                if (r_settle == '0) begin
                    r_out_y        <= maj_in;
                    r_out_ref      <= w_ref_lat;
                    r_out_hw       <= r_hw_lat;
                    r_out_mismatch <= w_mismatch;
                    r_out_valid    <= 1'b1;
                    if (w_mismatch && (r_err_count != {ERRW{1'b1}})) begin
                        r_err_count <= r_err_count + ERRW'(1);
                    end
                end else begin
                    r_settle <= r_settle - SCW'(1);
                end
            end

            if ((r_state == ST_OUTPUT) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign x_out        = r_x_out;
    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_ref      = r_out_ref;
    assign out_hw       = r_out_hw;
    assign out_mismatch = r_out_mismatch;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_maj_vector_loader.sv
// Directed bench for maj_vector_loader (N=65, W=8, SETTLE=1) with a behavioural majority core.
module tb_maj_vector_loader;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [64:0]   x_out;
    logic          maj_in;
    logic          out_valid;
    logic          out_ready;
    logic          out_y;
    logic          out_ref;
    logic [6:0]    out_hw;
    logic          out_mismatch;
    logic [15:0]   err_count;

    logic          force_en;
    logic          force_val;

    int n_checks;
    int n_errors;

    // Majority core model: y0 = popcount >= 33 unless forced.
    assign maj_in = force_en ? force_val : ($countones(x_out) >= 33);

    maj_vector_loader #(
        .N      (65),
        .W      (8),
        .SETTLE (1),
        .ERRW   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .x_out        (x_out),
        .maj_in       (maj_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_ref      (out_ref),
        .out_hw       (out_hw),
        .out_mismatch (out_mismatch),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends the low nch chunks of v (chunk 0 in the low byte), back to back.
    task automatic send_chunks(input logic [71:0] v, input int nch);
        int g;
        for (int k = 0; k < nch; k++) begin
            in_valid = 1'b1;
            in_data  = v[k*8 +: 8];
            g = 0;
            while (!in_ready && g < 50) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (g >= 50) check("ready_timeout", 96'd0, 96'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic expect_result(input string tag, input logic [64:0] xe, input logic [6:0] hwe,
                                 input logic refe, input logic ye, input logic mme, input logic [15:0] erre);
        check({tag, "_lat0"}, 96'(out_valid), 96'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 96'(out_valid), 96'd1);
        check({tag, "_x"},     96'(x_out), 96'(xe));
        check({tag, "_hw"},    96'(out_hw), 96'(hwe));
        check({tag, "_ref"},   96'(out_ref), 96'(refe));
        check({tag, "_y"},     96'(out_y), 96'(ye));
        check({tag, "_mm"},    96'(out_mismatch), 96'(mme));
        check({tag, "_err"},   96'(err_count), 96'(erre));
        check({tag, "_rdy"},   96'(in_ready), 96'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, 96'(out_valid), 96'd0);
        check({tag, "_rdy1"}, 96'(in_ready), 96'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_val = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_x",     96'(x_out), 96'd0);
        check("rst_err",   96'(err_count), 96'd0);
        check("rst_hw",    96'(out_hw), 96'd0);
        check("rst_rdy",   96'(in_ready), 96'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy_rel", 96'(in_ready), 96'd1);

        // All-zero vector
        send_chunks(72'h0, 9);
        expect_result("zero", 65'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        handshake("zero");

        // Exactly at threshold: 32 low ones plus bit 64
        send_chunks({8'h01, 32'h0, 32'hFFFF_FFFF}, 9);
        expect_result("thr_hi", {1'b1, 32'h0, 32'hFFFF_FFFF}, 7'd33, 1'b1, 1'b1, 1'b0, 16'd0);
        handshake("thr_hi");

        // One below threshold with the core forced high
        force_en  = 1'b1;
        force_val = 1'b1;
        send_chunks({40'h0, 32'hFFFF_FFFF}, 9);
        expect_result("thr_lo", {33'h0, 32'hFFFF_FFFF}, 7'd32, 1'b0, 1'b1, 1'b1, 16'd1);
        handshake("thr_lo");
        force_en = 1'b0;

        // Unused upper bits of the last chunk are discarded
        send_chunks({8'hFE, 64'h0}, 9);
        expect_result("mask", 65'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd1);
        handshake("mask");

        // Backpressure on an all-ones vector; chunks offered during OUTPUT are ignored
        send_chunks({72{1'b1}}, 9);
        expect_result("bp", {65{1'b1}}, 7'd65, 1'b1, 1'b1, 1'b0, 16'd1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 96'(out_valid), 96'd1);
            check("bp_hold_hw",    96'(out_hw), 96'd65);
            check("bp_hold_x",     96'(x_out), 96'({65{1'b1}}));
            check("bp_hold_rdy",   96'(in_ready), 96'd0);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        handshake("bp");

        // Partial load: x_out keeps the previous vector, then reset aborts the load
        send_chunks({72{1'b1}}, 4);
        check("part_x_held", 96'(x_out), 96'({65{1'b1}}));
        check("part_valid",  96'(out_valid), 96'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_x",     96'(x_out), 96'd0);
        check("mrst_err",   96'(err_count), 96'd0);
        check("mrst_valid", 96'(out_valid), 96'd0);
        check("mrst_rdy",   96'(in_ready), 96'd1);
        send_chunks(72'h0, 9);
        expect_result("post_rst", 65'h0, 7'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        handshake("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
